fft_frame_loader: RTL and testbench
===================================

Name: fft_frame_loader

Overview:
Initiator side of the fft_16 start/done interface. Collects a serial stream of signed audio samples into 16-sample frames using ping-pong double buffering. Presents one complete frame on time_samples, raises start, and holds the frame stable until the FFT answers with done. While the FFT runs on one bank, the other bank keeps filling. The block sits between the ADC sample path and fft_16.

Parameters:
WIDTH, 12, sample width in bits, two's complement.
N, 16, samples per frame. Fixed to match fft_16; only 16 is supported.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
sample_in  input  WIDTH  signed audio sample
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  loader can accept a sample this cycle
start  output  1  frame request to fft_16, level
done  input  1  fft_16 completion
time_samples  output  N x WIDTH  frame presented to fft_16; index 0 is the oldest sample
overrun  output  1  sticky: a valid sample was dropped
overrun_clr  input  1  clears overrun
busy  output  1  a frame is handed off and not yet released

Behaviour:
- Reset (rst=0, async):
  - all bank contents cleared to 0, both full flags cleared, fill index = 0.
  - wr_bank = 0, rd_bank = 0, FSM in IDLE.
  - start=0, busy=0, overrun=0, sample_ready=1 once rst deasserts, time_samples=all 0.
  - Reset mid-frame or mid-FFT discards all partial and pending frames. start drops asynchronously.
- Accept rule: a sample is accepted when sample_valid && sample_ready at a rising edge.
  - It is written to bank wr_bank at the current fill index, and the index increments.
  - Samples are stored bit-exact, with no scaling or sign change.
- sample_ready = !full[wr_bank].
- Frame complete: the 16th accepted sample (index 15) does all of the following on the same edge:
  - sets full[wr_bank];
  - wraps the index to 0;
  - toggles wr_bank.
- Drop: sample_valid && !sample_ready sets overrun on that edge and the sample is discarded.
  - overrun_clr clears overrun.
  - If a set and overrun_clr occur on the same edge, set wins.
- time_samples always drives bank rd_bank.
- FSM IDLE:
  - start=0, busy=0.
  - If full[rd_bank], go to WAIT: start=1 and busy=1 from the next edge.
  - Latency is therefore 1 cycle from the completing-sample edge to start high.
- FSM WAIT:
  - start=1, busy=1.
  - Bank rd_bank is never written in WAIT, so time_samples stays stable.
  - When done=1 is sampled: clear full[rd_bank], toggle rd_bank, return to IDLE. start=0 on that edge.
  - After done, start is low for at least one cycle, even if the other bank is already full.
- done while in IDLE is ignored.
- Simultaneous events:
  - A frame completing into one bank and a release of the other bank on the same edge both take effect.
  - If the fill bank is full while waiting on the read bank, sample_ready=0 until that done.
- Throughput: one sample per cycle sustained, as long as FFT latency is at most 15 cycles per frame.

Decomposition:
- Shared package fft_pkg:
  - localparam FFT_N=16 and default SAMPLE_WIDTH=12;
  - typedef sample_t (logic signed [SAMPLE_WIDTH-1:0]);
  - typedef frame_t (sample_t [0:FFT_N-1]);
  - enum loader_state_t {IDLE, WAIT}.
- One sub-module, fft_frame_bank, instantiated twice:
  - 16-entry register array with write enable, write index and full flag;
  - synchronous clear on release, async clear on rst.
- Bank-select, FSM and overrun logic stay in the top.

Test Plan:
- Reset, then stream -163,35,196,-128,55,193,3,-67,135,-56,-71,-129,37,190,81,-22 on consecutive cycles.
  - Required: start=1 one cycle after the 16th accept.
  - Required: time_samples[0]=-163 (12'hF5D), [15]=-22 (12'hFEA).
- Hold done=0 for 20 cycles while streaming 16 more samples (1..16), then a 17th sample.
  - Required: time_samples unchanged, sample_ready=0 after the 32nd accept, overrun=1 on the 33rd valid.
- Pulse done=1 for one cycle.
  - Required: start=0 on the next cycle and at least one low cycle, then start=1 with time_samples[0]=1 and [15]=16.
  - Required: sample_ready returns to 1.
- Assert overrun_clr on the same cycle as a dropped sample.
  - Required: overrun stays 1; overrun_clr alone next cycle gives 0.
- Assert rst=0 mid-frame (after 7 samples) and mid-WAIT.
  - Required: start drops immediately, time_samples=0, and the next 16 samples form a fresh frame starting at index 0.
- done=1 while IDLE with no frame pending.
  - Required: no state change, start stays 0, busy stays 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and sizes for the fft_16 front end.
package fft_pkg;

    localparam int unsigned FFT_N        = 16;
    localparam int unsigned SAMPLE_WIDTH = 12;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef sample_t [0:FFT_N-1]            frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } loader_state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer of the ping-pong pair: indexed sample writes plus a full flag.
module fft_frame_bank #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned N     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(N)-1:0]    wr_idx,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    set_full,
    input  logic                    clr,
    output logic [N-1:0][WIDTH-1:0] data,
    output logic                    full
);

    // Release empties the bank; a released bank is full, so it never sees writes on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            full <= 1'b0;
        end else if (clr) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (wr_en) begin
                data[wr_idx] <= wr_data;
            end
            if (set_full) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame collector feeding fft_16 over a start/done handshake.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_WIDTH,
    parameter int unsigned N     = FFT_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    start,
    input  logic                    done,
    output logic [N-1:0][WIDTH-1:0] time_samples,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    busy
);

    localparam int unsigned IDX_W = $clog2(N);

    loader_state_t                     state;
    loader_state_t                     next_state;
    logic [IDX_W-1:0]                  fill_idx;
    logic                              wr_bank;
    logic                              rd_bank;
    logic [1:0]                        full;
    logic [1:0][N-1:0][WIDTH-1:0]      bank_data;
    logic                              accept;
    logic                              drop;
    logic                              frame_done;
    logic                              release_frame;

    assign sample_ready  = !full[wr_bank];
    assign accept        = sample_valid && sample_ready;
    assign drop          = sample_valid && !sample_ready;
    assign frame_done    = accept && (fill_idx == IDX_W'(N - 1));
    assign release_frame = (state == WAIT) && done;
    assign time_samples  = bank_data[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic wr_sel;
        logic rd_sel;

        assign wr_sel = (wr_bank == 1'(b));
        assign rd_sel = (rd_bank == 1'(b));

        fft_frame_bank #(
            .WIDTH (WIDTH),
            .N     (N)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (accept && wr_sel),
            .wr_idx   (fill_idx),
            .wr_data  (sample_in),
            .set_full (frame_done && wr_sel),
            .clr      (release_frame && rd_sel),
            .data     (bank_data[b]),
            .full     (full[b])
        );
    end

    // Fill pointer, bank selects and sticky overrun (a new drop beats a clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_idx <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (accept) begin
                fill_idx <= frame_done ? '0 : fill_idx + IDX_W'(1);
            end
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
            if (release_frame) begin
                rd_bank <= ~rd_bank;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Returning to IDLE on done guarantees start is low for at least one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (full[rd_bank]) next_state = WAIT;
            WAIT:    if (done)          next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        if (state == WAIT) begin
            start = 1'b1;
            busy  = 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed vector bench for fft_frame_loader.
module tb_fft_frame_loader;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [11:0] din;
        logic        done;
        logic        clr;
        logic        e_start;
        logic        e_busy;
        logic        e_ready;
        logic        e_ovr;
        logic        chk_ts;
        logic [11:0] e_ts0;
        logic [11:0] e_ts15;
    } vec_t;

    logic               clk;
    logic               rst;
    logic signed [11:0] sample_in;
    logic               sample_valid;
    logic               sample_ready;
    logic               start;
    logic               done;
    logic [15:0][11:0]  time_samples;
    logic               overrun;
    logic               overrun_clr;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];
    int a_smp [16] = '{-163, 35, 196, -128, 55, 193, 3, -67, 135, -56, -71, -129, 37, 190, 81, -22};

    fft_frame_loader #(
        .WIDTH (12),
        .N     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .start        (start),
        .done         (done),
        .time_samples (time_samples),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic r, input logic v, input logic [11:0] d,
                                input logic dn, input logic c, input logic st, input logic bz,
                                input logic rd, input logic ov, input logic ck,
                                input logic [11:0] t0, input logic [11:0] t15);
        vec_t x;
        x.name = nm;  x.rst = r;  x.valid = v;  x.din = d;  x.done = dn;  x.clr = c;
        x.e_start = st;  x.e_busy = bz;  x.e_ready = rd;  x.e_ovr = ov;
        x.chk_ts = ck;  x.e_ts0 = t0;  x.e_ts15 = t15;
        return x;
    endfunction

    task automatic add(input vec_t x);
        vecs.push_back(x);
    endtask

    task automatic step(input vec_t v);
        rst          = v.rst;
        sample_valid = v.valid;
        sample_in    = v.din;
        done         = v.done;
        overrun_clr  = v.clr;
        @(posedge clk);
        #1;
        n_vec++;
        if (start !== v.e_start || busy !== v.e_busy || sample_ready !== v.e_ready ||
            overrun !== v.e_ovr ||
            (v.chk_ts && (time_samples[0] !== v.e_ts0 || time_samples[15] !== v.e_ts15))) begin
            n_err++;
            $display("FAIL %s: got start=%0b busy=%0b ready=%0b ovr=%0b ts0=%h ts15=%h, required start=%0b busy=%0b ready=%0b ovr=%0b ts0=%h ts15=%h (ts checked=%0b)",
                     v.name, start, busy, sample_ready, overrun, time_samples[0], time_samples[15],
                     v.e_start, v.e_busy, v.e_ready, v.e_ovr, v.e_ts0, v.e_ts15, v.chk_ts);
        end
    endtask

    // Asynchronous reset asserted between clock edges must clear outputs at once.
    task automatic async_reset_check(input string nm);
        #3;
        rst = 1'b0;
        #1;
        n_vec++;
        if (start !== 1'b0 || busy !== 1'b0 || time_samples !== '0) begin
            n_err++;
            $display("FAIL %s: got start=%0b busy=%0b ts_nonzero=%0b, required start=0 busy=0 ts all zero",
                     nm, start, busy, (time_samples !== '0));
        end
    endtask

    initial begin
        rst          = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        done         = 1'b0;
        overrun_clr  = 1'b0;

        add(mk("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12'h000, 12'h000));
        add(mk("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12'h000, 12'h000));
        for (int i = 0; i < 16; i++)
            add(mk("fill_a", 1, 1, 12'(a_smp[i]), 0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000));
        for (int i = 0; i < 15; i++)
            add(mk("fill_b", 1, 1, 12'(i + 1), 0, 0, 1, 1, 1, 0, 1, 12'hF5D, 12'hFEA));
        add(mk("fill_b_last", 1, 1, 12'd16, 0, 0, 1, 1, 0, 0, 1, 12'hF5D, 12'hFEA));
        add(mk("drop",        1, 1, 12'd99, 0, 0, 1, 1, 0, 1, 1, 12'hF5D, 12'hFEA));
        add(mk("drop_clr",    1, 1, 12'd98, 0, 1, 1, 1, 0, 1, 1, 12'hF5D, 12'hFEA));
        add(mk("clr_only",    1, 0, 12'd0,  0, 1, 1, 1, 0, 0, 1, 12'hF5D, 12'hFEA));
        add(mk("hold",        1, 0, 12'd0,  0, 0, 1, 1, 0, 0, 1, 12'hF5D, 12'hFEA));
        add(mk("done_a",      1, 0, 12'd0,  1, 0, 0, 0, 1, 0, 1, 12'd1,   12'd16));
        add(mk("restart_b",   1, 0, 12'd0,  0, 0, 1, 1, 1, 0, 1, 12'd1,   12'd16));
        add(mk("done_b",      1, 0, 12'd0,  1, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000));
        add(mk("done_idle",   1, 0, 12'd0,  1, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000));
        add(mk("idle",        1, 0, 12'd0,  0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000));
        for (int i = 0; i < 7; i++)
            add(mk("partial", 1, 1, 12'(500 + i), 0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i]);

        // Reset in the middle of a partial frame, then a fresh frame.
        async_reset_check("rst_mid_frame");
        step(mk("rst_hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12'h000, 12'h000));
        for (int i = 0; i < 16; i++)
            step(mk("fill_c", 1, 1, 12'(200 + i), 0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000));
        step(mk("start_c", 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 12'd200, 12'd215));

        // Reset while a frame is handed off.
        async_reset_check("rst_mid_wait");
        step(mk("rst_hold2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12'h000, 12'h000));
        for (int i = 0; i < 16; i++)
            step(mk("fill_d", 1, 1, 12'(-3 * (i + 1)), 0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000));
        step(mk("start_d", 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 12'hFFD, 12'hFD0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
